wb_sequencer: RTL

- Write-back controller for the SEQ register file when the register file is built with a single write port.
- Accepts one retired instruction per handshake: icode, Cnd, rA, rB, valE, valM.
- Derives the dstE and dstM destinations using Y86-64 rules.
- Serialises the two possible writes (E first, then M) onto one write port.
- Sits between the memory stage and the 15-entry register file and stalls upstream while writes are pending.

---
 rtl/y86_pkg.sv | 27 ++
 rtl/wb_dst_decode.sv | 34 +++
 rtl/wb_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, register IDs and
// the write-back sequencer state encoding.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'd0;
    localparam logic [3:0] INOP    = 4'd1;
    localparam logic [3:0] IRRMOVQ = 4'd2;
    localparam logic [3:0] IIRMOVQ = 4'd3;
    localparam logic [3:0] IRMMOVQ = 4'd4;
    localparam logic [3:0] IMRMOVQ = 4'd5;
    localparam logic [3:0] IOPQ    = 4'd6;
    localparam logic [3:0] IJXX    = 4'd7;
    localparam logic [3:0] ICALL   = 4'd8;
    localparam logic [3:0] IRET    = 4'd9;
    localparam logic [3:0] IPUSHQ  = 4'd10;
    localparam logic [3:0] IPOPQ   = 4'd11;

    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        WR_E,
        WR_M
    } state_t;

endpackage

// File: rtl/wb_dst_decode.sv
// Y86-64 write-back destination decode (dstE / dstM).
// Shared with the decode stage for hazard detection.
module wb_dst_decode
    import y86_pkg::*;
#(
    parameter int               REG_W  = 4,
    parameter logic [REG_W-1:0] NO_REG = RNONE,
    parameter logic [REG_W-1:0] SP_REG = RRSP
) (
    input  logic [3:0]       icode,
    input  logic             cnd,
    input  logic [REG_W-1:0] ra,
    input  logic [REG_W-1:0] rb,
    output logic [REG_W-1:0] dst_e,
    output logic [REG_W-1:0] dst_m
);

    always_comb begin
        dst_e = NO_REG;
        dst_m = NO_REG;
        case (icode)
            IRRMOVQ:               dst_e = cnd ? rb : NO_REG;
            IIRMOVQ, IOPQ:         dst_e = rb;
            IMRMOVQ:               dst_m = ra;
            ICALL, IRET, IPUSHQ:   dst_e = SP_REG;
            IPOPQ: begin
                dst_e = SP_REG;
                dst_m = ra;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/wb_sequencer.sv
// Serialises the E and M register writes of one retired instruction
// onto a single write port. Optional write counter: WB_COUNT_EN.
module wb_sequencer #(
    parameter int               DATA_W = 64,
    parameter int               REG_W  = 4,
    parameter logic [REG_W-1:0] RNONE  = 4'hF,
    parameter logic [REG_W-1:0] RSP    = 4'h4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic              Cnd,
    input  logic [REG_W-1:0]  rA,
    input  logic [REG_W-1:0]  rB,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_dst,
    output logic [DATA_W-1:0] rf_data,
    output logic              busy
`ifdef WB_COUNT_EN
    ,
    output logic [31:0]       wb_count
`endif
);

    import y86_pkg::*;

    state_t            state;
    state_t            state_n;
    logic [REG_W-1:0]  dst_e;
    logic [REG_W-1:0]  dst_m;
    logic [REG_W-1:0]  dste_q;
    logic [REG_W-1:0]  dstm_q;
    logic [DATA_W-1:0] vale_q;
    logic [DATA_W-1:0] valm_q;
    logic              final_wr;
    logic              accept;

    wb_dst_decode #(
        .REG_W  (REG_W),
        .NO_REG (RNONE),
        .SP_REG (RSP)
    ) u_dst (
        .icode (icode),
        .cnd   (Cnd),
        .ra    (rA),
        .rb    (rB),
        .dst_e (dst_e),
        .dst_m (dst_m)
    );

    always_comb begin
        final_wr = (state == WR_M) || (state == WR_E && dstm_q == RNONE);
        in_ready = (state == IDLE) || final_wr;
        accept   = in_valid && in_ready;

        state_n = IDLE;
        if (state == WR_E && dstm_q != RNONE)
            state_n = WR_M;
        // A request taken during the final write starts immediately.
        if (accept) begin
            if (dst_e != RNONE)
                state_n = WR_E;
            else if (dst_m != RNONE)
                state_n = WR_M;
            else
                state_n = IDLE;
        end

        rf_we   = 1'b0;
        rf_dst  = RNONE;
        rf_data = '0;
        case (state)
            WR_E: begin
                rf_we   = 1'b1;
                rf_dst  = dste_q;
                rf_data = vale_q;
            end
            WR_M: begin
                rf_we   = 1'b1;
                rf_dst  = dstm_q;
                rf_data = valm_q;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            dste_q <= RNONE;
            dstm_q <= RNONE;
            vale_q <= '0;
            valm_q <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                dste_q <= dst_e;
                dstm_q <= dst_m;
                vale_q <= valE;
                valm_q <= valM;
            end
        end
    end

`ifdef WB_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else if (rf_we && count_q != 32'hFFFF_FFFF)
            count_q <= count_q + 32'd1;
    end

    assign wb_count = count_q;
`endif

endmodule
